pwm_bank: RTL
=============

Name: pwm_bank

Overview:
- Parametrised multi-channel PWM generator; successor to the single-bank 8-bit PWM peripheral behind the onboarding SPI register file.
- Sits between the register-write interface (SPI decoder) and the uo_out/uio_out pads.
- Adds configurable channel count, counter width, a prescaler, a programmable period, and glitch-free shadowed duty/period updates at period boundaries.

Parameters:
- NUM_CH, 8, number of PWM channels (1..16)
- CNT_W, 8, width of the period counter and of the duty/period registers
- PRESC_W, 12, width of the clock prescaler
- ADDR_W, derived localparam = $clog2(NUM_CH+1); not user-set

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  register write strobe, single cycle
- wr_addr  in  ADDR_W  0..NUM_CH-1 = duty[ch]; NUM_CH = period; others ignored
- wr_data  in  CNT_W  write data
- presc  in  PRESC_W  prescaler divide value; tick every presc+1 clk cycles
- ch_en  in  NUM_CH  per-channel output enable
- pwm_out  out  NUM_CH  registered PWM outputs
- period_start  out  1  one-cycle pulse on each period wrap

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - pre_cnt=0, cnt=0.
  - Staged and shadow duty = 0.
  - Staged and shadow period = 2^CNT_W-1.
  - pwm_out=0, period_start=0.
  - Reset mid-period aborts the period; counting restarts at cnt=0 from the first cycle after rst falls.
- Prescaler:
  - pre_cnt increments each clk.
  - When pre_cnt == presc: tick=1 and pre_cnt<=0.
  - presc=0 gives a tick every cycle.
  - If presc is lowered below the current pre_cnt, the next cycle ticks and pre_cnt<=0; it must not wrap through 2^PRESC_W.
- Period counter:
  - On tick: if cnt == period_sh then cnt<=0 (wrap), else cnt<=cnt+1.
  - One period = period_sh+1 ticks.
- Wrap event (tick && cnt==period_sh):
  - Shadow duty[ch] and shadow period load from the staged registers.
  - period_start=1 in the following cycle (registered with the counter wrap).
- Writes:
  - wr_en with a valid address updates the staged register only, at the clock edge.
  - Invalid addresses (>NUM_CH) are ignored.
  - A write coinciding with a wrap event: the shadow captures the pre-write staged value; the new value takes effect at the next wrap.
  - Writes never alter the live output mid-period.
- Output:
  - pwm_out[i] <= ch_en[i] && (cnt < duty_sh[i]), evaluated on the current registered cnt, so pwm_out lags cnt by 1 clk.
  - duty_sh=0: constantly low.
  - duty_sh > period_sh: constantly high (100%), with no glitch at wrap.
  - ch_en[i] falling forces pwm_out[i]=0 on the next clk edge, independent of tick.
- Arithmetic:
  - All comparisons unsigned, CNT_W bits; no sign extension.
  - Period 0 allowed: each tick is a wrap; output is 100% if duty≥1, else 0%.

Decomposition:
- Shared package pwm_pkg holds:
  - localparam ADDR_PERIOD = NUM_CH
  - reset constants PERIOD_RST = '1 and DUTY_RST = '0
  - a typedef for the CNT_W duty vector
- One sub-module, pwm_prescaler (pre_cnt, presc compare, tick output), instantiated once.
- Per-channel comparators are generated inline in pwm_bank.

Test Plan:
- Reset, then defaults, presc=0, ch_en=all 1s → pwm_out=0 for 600 cycles; period_start pulses every 256 cycles.
- Write period=9, duty[0]=5, duty[1]=0, duty[2]=10; presc=0 → after the next wrap, ch0 high 5/low 5 cycles, ch1 always 0, ch2 always 1; period_start every 10 clk.
- presc=3, period=3, duty[0]=2 → ch0 high 8 clk, low 8 clk; period_start every 16 clk.
- Mid-period write duty[0]=1 (was 5, period=9) → current period keeps a 5-cycle high; following period shows a 1-cycle high. Repeat with the write on the exact wrap cycle → change is delayed one further period.
- Drop ch_en[0] while ch0 is high → pwm_out[0]=0 next cycle; re-enable resumes in phase with cnt.
- Assert rst for 1 cycle mid-period, with period=9 and duty[0]=5 written beforehand → all outputs 0; shadow and staged registers return to defaults (period 255, duty 0); writes must be reissued.
- Write to address NUM_CH+1 → no register changes.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM bank: default geometry, register map
// anchor and the reset values of the duty/period registers.
package pwm_pkg;

  localparam int unsigned PWM_NUM_CH  = 8;
  localparam int unsigned PWM_CNT_W   = 8;
  localparam int unsigned PWM_PRESC_W = 12;

  // Register map: addresses below ADDR_PERIOD select a duty register.
  localparam int unsigned ADDR_PERIOD = PWM_NUM_CH;

  typedef logic [PWM_CNT_W-1:0] duty_t;

  localparam duty_t PERIOD_RST = '1;
  localparam duty_t DUTY_RST   = '0;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one-cycle tick every presc+1 clocks.
import pwm_pkg::*;

module pwm_prescaler #(
  parameter int PRESC_W = PWM_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pre_cnt;

  // >= rather than == so that lowering presc below pre_cnt ticks at once
  // instead of running all the way round the counter.
  assign tick = (pre_cnt >= presc);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator with staged duty/period registers that are
// copied into the live shadows only at a period wrap.
import pwm_pkg::*;

module pwm_bank #(
  parameter  int NUM_CH  = PWM_NUM_CH,
  parameter  int CNT_W   = PWM_CNT_W,
  parameter  int PRESC_W = PWM_PRESC_W,
  localparam int ADDR_W  = $clog2(NUM_CH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [CNT_W-1:0]   wr_data,
  input  logic [PRESC_W-1:0] presc,
  input  logic [NUM_CH-1:0]  ch_en,
  output logic [NUM_CH-1:0]  pwm_out,
  output logic               period_start
);

  localparam int ADDR_PER = NUM_CH;

  logic               tick;
  logic               wrap;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   period_stg;
  logic [CNT_W-1:0]   period_sh;
  logic [CNT_W-1:0]   duty_stg [NUM_CH];
  logic [CNT_W-1:0]   duty_sh  [NUM_CH];
  logic [NUM_CH-1:0]  pwm_nxt;

  pwm_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .presc (presc),
    .tick  (tick)
  );

  assign wrap = tick && (cnt == period_sh);

  // A duty above the period never matches, so the channel stays high across wraps.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
    assign pwm_nxt[g] = ch_en[g] && (cnt < duty_sh[g]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      period_stg   <= '1;
      period_sh    <= '1;
      pwm_out      <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_stg[i] <= '0;
        duty_sh[i]  <= '0;
      end
    end else begin
      pwm_out      <= pwm_nxt;
      period_start <= wrap;

      if (tick) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end

      // Shadows sample the staged values before any same-cycle write lands.
      if (wrap) begin
        period_sh <= period_stg;
        for (int i = 0; i < NUM_CH; i++) begin
          duty_sh[i] <= duty_stg[i];
        end
      end

      if (wr_en) begin
        if (wr_addr == ADDR_W'(ADDR_PER)) begin
          period_stg <= wr_data;
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_addr == ADDR_W'(i)) begin
            duty_stg[i] <= wr_data;
          end
        end
      end
    end
  end

endmodule
